frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Steps an animation through NUM_FRAMES frames at a CPU-programmable rate,
//   optionally gating each step on a revolution-boundary pulse, and publishes
//   the current frame number together with its texture ROM base address.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   cfg_we        one-cycle MMIO write strobe
//   cfg_sel[1:0]  0 DIV, 1 CTRL, 2 JUMP, 3 reserved (write accepted, no effect)
//   cfg_data[31:0] write data
//   rev_sync      one-cycle pulse at the revolution boundary
//   frame_idx[7:0]           current frame number
//   frame_offset[ADDR_W-1:0] frame_idx*FRAME_SIZE
//   frame_tick    high for the cycle in which a new frame_idx/frame_offset is
//                 first presented (registered alongside them)
//   state[1:0]    0 IDLE, 1 COUNT, 2 WAIT_SYNC
//   done          sticky; set when a one-shot run stops on its end frame
//
// CTRL layout: {oneshot[3], sync_en[2], dir[1], run[0]}
module frame_sequencer #(
    parameter int NUM_FRAMES  = 30,
    parameter int FRAME_SIZE  = 3328,
    parameter int ADDR_W      = 17,
    parameter int DEFAULT_DIV = 6666667
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [31:0]       cfg_data,
    input  logic              rev_sync,
    output logic [7:0]        frame_idx,
    output logic [ADDR_W-1:0] frame_offset,
    output logic              frame_tick,
    output logic [1:0]        state,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNT     = 2'd1,
        WAIT_SYNC = 2'd2
    } state_t;

    localparam logic [1:0]        SEL_DIV   = 2'd0;
    localparam logic [1:0]        SEL_CTRL  = 2'd1;
    localparam logic [1:0]        SEL_JUMP  = 2'd2;

    localparam logic [7:0]        LAST_IDX  = 8'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] STEP_OFF  = ADDR_W'(FRAME_SIZE);
    localparam logic [ADDR_W-1:0] LAST_OFF  = ADDR_W'((NUM_FRAMES - 1) * FRAME_SIZE);
    localparam logic [31:0]       NF32      = 32'(NUM_FRAMES);
    localparam logic [31:0]       FS32      = 32'(FRAME_SIZE);
    localparam logic [31:0]       DIV_RST   = 32'(DEFAULT_DIV);

    state_t              state_q, state_n;
    logic [31:0]         div_q, div_n;
    logic [3:0]          ctrl_q, ctrl_n;
    logic [31:0]         timer_q, timer_n;
    logic [7:0]          idx_n;
    logic [ADDR_W-1:0]   off_n;
    logic                tick_n;
    logic                done_n;

    logic                advance;
    logic                at_end;

    wire run     = ctrl_q[0];
    wire dir     = ctrl_q[1];
    wire sync_en = ctrl_q[2];
    wire oneshot = ctrl_q[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= DIV_RST;
            ctrl_q       <= '0;
            timer_q      <= '0;
            frame_idx    <= '0;
            frame_offset <= '0;
            frame_tick   <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_n;
            div_q        <= div_n;
            ctrl_q       <= ctrl_n;
            timer_q      <= timer_n;
            frame_idx    <= idx_n;
            frame_offset <= off_n;
            frame_tick   <= tick_n;
            done         <= done_n;
        end
    end

    // A cfg write owns the cycle: any expiry or rev_sync that coincides with
    // it is discarded rather than queued.
    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        ctrl_n  = ctrl_q;
        timer_n = timer_q;
        idx_n   = frame_idx;
        off_n   = frame_offset;
        tick_n  = 1'b0;
        done_n  = done;
        advance = 1'b0;
        at_end  = 1'b0;

        if (cfg_we) begin
            case (cfg_sel)
                SEL_DIV: begin
                    div_n   = (cfg_data == 32'd0) ? 32'd1 : cfg_data;
                    timer_n = '0;
                end
                SEL_CTRL: begin
                    ctrl_n = cfg_data[3:0];
                    done_n = 1'b0;
                    if (cfg_data[0] && !run) begin
                        state_n = COUNT;
                        timer_n = '0;
                    end else if (!cfg_data[0] && run) begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end
                SEL_JUMP: begin
                    if (cfg_data < NF32) begin
                        idx_n   = cfg_data[7:0];
                        off_n   = ADDR_W'(cfg_data * FS32);
                        tick_n  = 1'b1;
                        timer_n = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    timer_n = '0;
                end
                COUNT: begin
                    if (timer_q == div_q - 32'd1) begin
                        timer_n = '0;
                        if (sync_en) begin
                            state_n = WAIT_SYNC;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        timer_n = timer_q + 32'd1;
                    end
                end
                WAIT_SYNC: begin
                    if (rev_sync) begin
                        advance = 1'b1;
                        state_n = COUNT;
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end

        // Offset tracks the index by add/subtract only; the wrap points are
        // loaded as constants so the two never drift apart.
        if (advance) begin
            at_end = dir ? (frame_idx == 8'd0) : (frame_idx == LAST_IDX);
            if (oneshot && at_end) begin
                ctrl_n[0] = 1'b0;
                done_n    = 1'b1;
                state_n   = IDLE;
                timer_n   = '0;
            end else begin
                tick_n = 1'b1;
                if (!dir) begin
                    if (at_end) begin
                        idx_n = '0;
                        off_n = '0;
                    end else begin
                        idx_n = frame_idx + 8'd1;
                        off_n = frame_offset + STEP_OFF;
                    end
                end else begin
                    if (at_end) begin
                        idx_n = LAST_IDX;
                        off_n = LAST_OFF;
                    end else begin
                        idx_n = frame_idx - 8'd1;
                        off_n = frame_offset - STEP_OFF;
                    end
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
//   Directed scenarios followed by a randomized phase, all checked every cycle
//   against a behavioural model that keeps the frame number as a plain integer
//   (modulo arithmetic) and derives the ROM base by multiplication.
module tb_frame_sequencer;

    localparam int NF   = 30;
    localparam int FS   = 3328;
    localparam int AW   = 17;
    localparam int DDIV = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [31:0]   cfg_data;
    logic          rev_sync;
    logic [7:0]    frame_idx;
    logic [AW-1:0] frame_offset;
    logic          frame_tick;
    logic [1:0]    state;
    logic          done;

    frame_sequencer #(
        .NUM_FRAMES (NF),
        .FRAME_SIZE (FS),
        .ADDR_W     (AW),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .rev_sync    (rev_sync),
        .frame_idx   (frame_idx),
        .frame_offset(frame_offset),
        .frame_tick  (frame_tick),
        .state       (state),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ticks_seen = 0;
    int max_off = 0;

    // Reference model: run/dir/sync/oneshot flags, frame number, divider,
    // cycles elapsed in the current frame period, mode (0 idle, 1 count, 2 wait).
    int          m_idx;
    int          m_mode;
    int unsigned m_div;
    int unsigned m_elapsed;
    bit          m_run, m_dir, m_sync, m_oneshot;
    bit          m_done;
    bit          m_tick;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_advance();
        bit wraps;
        wraps = m_dir ? (m_idx == 0) : (m_idx == NF - 1);
        if (m_oneshot && wraps) begin
            m_run  = 0;
            m_done = 1;
            m_mode = 0;
        end else begin
            m_idx  = m_dir ? (m_idx + NF - 1) % NF : (m_idx + 1) % NF;
            m_tick = 1;
        end
    endfunction

    function automatic void model_step(input bit rst, input bit we, input bit [1:0] sel,
                                       input bit [31:0] d, input bit sync);
        m_tick = 0;
        if (rst) begin
            m_idx = 0; m_mode = 0; m_div = DDIV; m_elapsed = 0;
            m_run = 0; m_dir = 0; m_sync = 0; m_oneshot = 0; m_done = 0;
            return;
        end
        if (we) begin
            if (sel == 2'd0) begin
                m_div = (d == 0) ? 1 : d;
                m_elapsed = 0;
            end else if (sel == 2'd1) begin
                if (d[0] && !m_run) begin m_mode = 1; m_elapsed = 0; end
                if (!d[0] && m_run) begin m_mode = 0; m_elapsed = 0; end
                {m_oneshot, m_sync, m_dir, m_run} = d[3:0];
                m_done = 0;
            end else if (sel == 2'd2) begin
                if (d < NF) begin
                    m_idx = int'(d);
                    m_tick = 1;
                    m_elapsed = 0;
                end
            end
            return;
        end
        if (m_mode == 1) begin
            m_elapsed++;
            if (m_elapsed == m_div) begin
                m_elapsed = 0;
                if (m_sync) m_mode = 2;
                else model_advance();
            end
        end else if (m_mode == 2 && sync) begin
            m_mode = 1;
            model_advance();
        end
    endfunction

    task automatic step(input bit rst, input bit we, input bit [1:0] sel,
                        input bit [31:0] d, input bit sync);
        reset = rst; cfg_we = we; cfg_sel = sel; cfg_data = d; rev_sync = sync;
        @(posedge clk);
        model_step(rst, we, sel, d, sync);
        #1;
        check("frame_idx", frame_idx, m_idx);
        check("frame_offset", frame_offset, m_idx * FS);
        check("frame_tick", frame_tick, m_tick);
        check("state", state, m_mode);
        check("done", done, m_done);
        if (frame_tick === 1'b1) ticks_seen++;
        if (int'(frame_offset) > max_off) max_off = int'(frame_offset);
        reset = 0; cfg_we = 0; cfg_sel = 0; cfg_data = 0; rev_sync = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 32'd0, 0);
    endtask

    task automatic wr(input bit [1:0] sel, input bit [31:0] d);
        step(0, 1, sel, d, 0);
    endtask

    initial begin
        reset = 1; cfg_we = 0; cfg_sel = 0; cfg_data = 0; rev_sync = 0;
        #2;

        // Reset values
        step(1, 0, 2'd0, 32'd0, 0);
        step(1, 0, 2'd0, 32'd0, 0);
        check("rst_idx", frame_idx, 0);
        check("rst_state", state, 0);

        // Default divider after reset
        wr(2'd1, 32'd1);
        idle(6);
        check("defdiv_before", frame_idx, 0);
        idle(1);
        check("defdiv_idx", frame_idx, 1);

        // Forward sweep with DIV=4 from frame 0
        wr(2'd0, 32'd4);
        wr(2'd2, 32'd0);
        ticks_seen = 0; max_off = 0;
        idle(NF * 4);
        check("fwd_ticks", ticks_seen, NF);
        check("fwd_max_off", max_off, 96512);
        check("fwd_wrap_idx", frame_idx, 0);

        // Reverse from frame 0
        wr(2'd1, 32'd3);
        idle(4);
        check("rev_idx1", frame_idx, 29);
        check("rev_off1", frame_offset, 96512);
        idle(4);
        check("rev_idx2", frame_idx, 28);
        check("rev_off2", frame_offset, 93184);

        // Sync-gated stepping
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd2);
        wr(2'd1, 32'd5);
        idle(2);
        check("sync_wait_state", state, 2);
        idle(3);
        check("sync_hold_idx", frame_idx, 28);
        step(0, 0, 2'd0, 32'd0, 1);
        check("sync_adv_idx", frame_idx, 29);
        check("sync_adv_state", state, 1);
        step(0, 0, 2'd0, 32'd0, 1);
        check("sync_in_count_idx", frame_idx, 29);
        idle(1);
        check("sync_wait_again", state, 2);

        // Reset while waiting for sync
        step(1, 0, 2'd0, 32'd0, 0);
        check("rst_ws_idx", frame_idx, 0);
        check("rst_ws_state", state, 0);
        idle(3);

        // One-shot stopping at the end frame
        wr(2'd2, 32'd28);
        wr(2'd0, 32'd3);
        wr(2'd1, 32'd9);
        idle(3);
        check("os_idx", frame_idx, 29);
        idle(3);
        check("os_done", done, 1);
        check("os_state", state, 0);
        ticks_seen = 0;
        idle(10);
        check("os_no_ticks", ticks_seen, 0);
        check("os_idx_held", frame_idx, 29);

        // Out-of-range jump, then jump colliding with expiry
        wr(2'd2, 32'd30);
        check("jump30_idx", frame_idx, 29);
        wr(2'd1, 32'd1);
        check("ctrl_clears_done", done, 0);
        wr(2'd0, 32'd4);
        idle(3);
        ticks_seen = 0;
        wr(2'd2, 32'd5);
        check("jump5_idx", frame_idx, 5);
        check("jump5_off", frame_offset, 16640);
        idle(3);
        check("jump5_single_tick", ticks_seen, 1);

        // DIV=0 behaves as 1: a new frame every cycle
        wr(2'd0, 32'd0);
        ticks_seen = 0;
        idle(5);
        check("div0_ticks", ticks_seen, 5);
        check("div0_idx", frame_idx, 10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r, w, s;
            bit [1:0]    sl;
            bit [31:0]   dv;
            r  = ($urandom_range(0, 299) == 0);
            w  = ($urandom_range(0, 11) == 0);
            s  = ($urandom_range(0, 3) == 0);
            sl = 2'($urandom_range(0, 3));
            case (sl)
                2'd0:    dv = $urandom_range(0, 5);
                2'd1:    dv = $urandom_range(0, 15) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
                2'd2:    dv = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 33);
                default: dv = $urandom;
            endcase
            step(r, w, sl, dv, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
